// File: rtl/matrix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_frame_sequencer
// Upstream feeder for the matrix loader. Parses a 4-nibble header (R1,C1,R2,C2)
// from a valid/ready host stream and validates the dimensions. It then buffers
// all N1+N2 operand nibbles. Once the frame is complete, it replays the frame
// gap-free: 5 header cycles (pad,R1,C1,R2,C2) with ld_ctrl=1, followed by the
// data cycles with ld_ctrl=0. An illegal header parks the block in ERR with a
// sticky err/err_code until the next start.
//
// Ports
//   CLK, RST_N          clock / asynchronous active-low reset
//   start               1-cycle pulse, honoured in IDLE and ERR only
//   in_data/in_valid    host nibble stream
//   in_ready            nibble accepted when in_valid & in_ready
//   ld_data/ld_ctrl     registered nibble + header flag to the loader
//   ld_frame            ld_data/ld_ctrl meaningful this cycle
//   done                1-cycle pulse after the last element
//   err/err_code        sticky error: 01 zero dim, 10 C1!=R2, 11 R*C>MAX_ELEMS
// -----------------------------------------------------------------------------
module matrix_frame_sequencer #(
  parameter int MAX_ELEMS = 5,
  parameter int DW        = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] ld_data,
  output logic          ld_ctrl,
  output logic          ld_frame,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int DEPTH = 2 * MAX_ELEMS;
  localparam int PW    = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_CHK    = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_EMIT_H = 3'd4;
  localparam logic [2:0] S_EMIT_D = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]    r_state;
  logic [PW-1:0] r_cnt;      // header index / emit index
  logic [PW-1:0] r_wr_ptr;   // next buffer slot in FILL
  logic [PW-1:0] r_total;    // N1+N2, latched in CHK
  logic [DW-1:0] r_r1, r_c1, r_r2, r_c2;
  logic [DW-1:0] r_ld_data;
  logic          r_ld_ctrl, r_ld_frame, r_done, r_err;
  logic [1:0]    r_err_code;
  logic [DW-1:0] r_buf [DEPTH];

  logic          w_xfer;
  logic          w_buf_we;
  logic [7:0]    w_n1, w_n2;
  logic [DW-1:0] w_hdr_nib;

  assign in_ready = (r_state == S_HDR) || (r_state == S_FILL);
  assign w_xfer   = in_valid & in_ready;
  assign w_buf_we = w_xfer && (r_state == S_FILL);

  assign w_n1 = 8'(r_r1) * 8'(r_c1);
  assign w_n2 = 8'(r_r2) * 8'(r_c2);

  // Header replay order: a zero pad nibble, then the four dims as received.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_hdr_nib = '0;
    case (r_cnt)
      PW'(1):  w_hdr_nib = r_r1;
      PW'(2):  w_hdr_nib = r_c1;
      PW'(3):  w_hdr_nib = r_r2;
      PW'(4):  w_hdr_nib = r_c2;
      default: w_hdr_nib = '0;
    endcase
  end

  // The loader outputs are registered from the current state. As a result,
  // ld_frame trails EMIT_H/EMIT_D by one cycle, and done trails DONE by one.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_total    <= '0;
      r_r1       <= '0;
      r_c1       <= '0;
      r_r2       <= '0;
      r_c2       <= '0;
      r_ld_data  <= '0;
      r_ld_ctrl  <= 1'b0;
      r_ld_frame <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_ld_data  <= '0;
      r_ld_ctrl  <= 1'b0;
      r_ld_frame <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_state    <= S_HDR;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            case (r_cnt[1:0])
              2'd0: r_r1 <= in_data;
              2'd1: r_c1 <= in_data;
              2'd2: r_r2 <= in_data;
              default: r_c2 <= in_data;
            endcase
            if (r_cnt == PW'(3)) begin
              r_state <= S_CHK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + PW'(1);
            end
          end
        end
        S_CHK: begin
          // Priority: zero dim, then inner-dim mismatch, then size limit.
          if (r_r1 == '0 || r_c1 == '0 || r_r2 == '0 || r_c2 == '0) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
          end else if (r_c1 != r_r2) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end else if (w_n1 > 8'(MAX_ELEMS) || w_n2 > 8'(MAX_ELEMS)) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end else begin
            r_state  <= S_FILL;
            r_total  <= w_n1[PW-1:0] + w_n2[PW-1:0];
            r_wr_ptr <= '0;
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (r_wr_ptr == r_total - PW'(1)) begin
              r_state <= S_EMIT_H;
              r_cnt   <= '0;
            end
          end
        end
        S_EMIT_H: begin
          r_ld_frame <= 1'b1;
          r_ld_ctrl  <= 1'b1;
          r_ld_data  <= w_hdr_nib;
          if (r_cnt == PW'(4)) begin
            r_state <= S_EMIT_D;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        S_EMIT_D: begin
          r_ld_frame <= 1'b1;
          r_ld_data  <= r_buf[r_cnt];
          if (r_cnt == r_total - PW'(1)) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the operand buffer is deliberately left out of reset. Every slot is
  // written in FILL before EMIT_D reads it, so reset would only add cost.
  always_ff @(posedge CLK) begin
    if (w_buf_we) r_buf[r_wr_ptr] <= in_data;
  end

  assign ld_data  = r_ld_data;
  assign ld_ctrl  = r_ld_ctrl;
  assign ld_frame = r_ld_frame;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule
